// File: rtl/approx_mul1.sv
// rtl/approx_mul1.sv - 2x2-bit approximate unsigned multiplier, 3-bit registered product
module approx_mul1 (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [2:0] out,
    output logic       out_valid,
    output logic       approx_err
);

    logic [2:0] prod;
    logic       err;

    // Partial-product core: the bit-1 OR drops the carry that 3x3 would need,
    // which is why 3x3 collapses to 7 instead of 9.
    always_comb begin
        prod    = 3'b000;
        prod[0] = a[0] & b[0];
        prod[1] = (a[1] & b[0]) | (a[0] & b[1]);
        prod[2] = a[1] & b[1];
        err     = (a == 2'd3) && (b == 2'd3);
    end

    // Output registers: load on a valid input, otherwise hold product/flag and drop valid.
    always_ff @(posedge clk) begin
        if (reset) begin
            out        <= 3'b000;
            out_valid  <= 1'b0;
            approx_err <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out        <= prod;
                approx_err <= err;
            end
        end
    end

endmodule

// File: tb/tb_approx_mul1.sv
// tb/tb_approx_mul1.sv - scoreboard bench for approx_mul1 with random and directed stimulus
module tb_approx_mul1;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [1:0] a;
    logic [1:0] b;
    logic [2:0] out;
    logic       out_valid;
    logic       approx_err;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [2:0] prod;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    logic       rst_prev  = 1'b1;
    logic       exp_valid = 1'b0;
    logic [2:0] last_out  = 3'd0;
    logic       last_err  = 1'b0;
    bit         done      = 0;

    approx_mul1 dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .out        (out),
        .out_valid  (out_valid),
        .approx_err (approx_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: true product saturated to the 3-bit range; err when it differs.
    function automatic exp_t model(input int x, input int y);
        exp_t r;
        int p;
        p = x * y;
        r.prod = (p > 7) ? 3'd7 : 3'(p);
        r.err  = (p > 7);
        return r;
    endfunction

    task automatic issue(input logic r, input logic v, input logic [1:0] x, input logic [1:0] y);
        @(posedge clk);
        #1;
        reset    = r;
        in_valid = v;
        a        = x;
        b        = y;
        if (!r && v) exp_q.push_back(model(int'(x), int'(y)));
    endtask

    // Capture what the edge is about to apply, from the inputs the edge sees.
    always @(posedge clk) begin
        rst_prev  = reset;
        exp_valid = !reset && in_valid;
    end

    // Monitor: compare on the falling edge, away from the sampling edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_prev) begin
            check("reset_out", 8'(out), 8'd0);
            check("reset_valid", 8'(out_valid), 8'd0);
            check("reset_err", 8'(approx_err), 8'd0);
            last_out = 3'd0;
            last_err = 1'b0;
        end else begin
            check("out_valid", 8'(out_valid), 8'(exp_valid));
            if (exp_valid) begin
                if (exp_q.size() == 0) begin
                    check("scoreboard_underflow", 8'd1, 8'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("product", 8'(out), 8'(e.prod));
                    check("approx_err", 8'(approx_err), 8'(e.err));
                    last_out = e.prod;
                    last_err = e.err;
                end
            end else begin
                check("hold_out", 8'(out), 8'(last_out));
                check("hold_err", 8'(approx_err), 8'(last_err));
            end
        end
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        a        = 2'd0;
        b        = 2'd0;
        issue(1'b1, 1'b0, 2'd0, 2'd0);
        issue(1'b0, 1'b0, 2'd0, 2'd0);

        for (int i = 0; i < 16; i++) issue(1'b0, 1'b1, 2'(i / 4), 2'(i % 4));
        issue(1'b0, 1'b0, 2'd0, 2'd0);

        issue(1'b0, 1'b1, 2'd3, 2'd3);
        issue(1'b0, 1'b0, 2'd0, 2'd0);

        issue(1'b0, 1'b1, 2'd2, 2'd3);
        issue(1'b0, 1'b0, 2'd3, 2'd3);
        issue(1'b0, 1'b0, 2'd3, 2'd3);

        issue(1'b0, 1'b1, 2'd3, 2'd3);
        issue(1'b1, 1'b1, 2'd3, 2'd1);
        issue(1'b0, 1'b1, 2'd3, 2'd1);
        issue(1'b0, 1'b0, 2'd0, 2'd0);

        issue(1'b0, 1'b1, 2'd1, 2'd1);
        issue(1'b0, 1'b1, 2'd2, 2'd2);
        issue(1'b0, 1'b1, 2'd3, 2'd3);
        issue(1'b0, 1'b1, 2'd0, 2'd3);
        issue(1'b0, 1'b0, 2'd1, 2'd2);

        for (int i = 0; i < 300; i++) begin
            issue(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
        end

        issue(1'b0, 1'b0, 2'd0, 2'd0);
        issue(1'b0, 1'b0, 2'd0, 2'd0);
        @(posedge clk);
        #1;
        check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        done = 1;
    end

    initial begin
        fork
            wait (done);
            #100000;
        join_any
        if (!done) begin
            fails++;
            $display("FAIL timeout: stimulus did not complete, expected completion before %0t", $time);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
